// File: rtl/sike_pkg.sv
// Shared constants and state encoding for the serial modular subtractor.
// P434 is the SIKE p434 prime.
package sike_pkg;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  localparam int WIDTH = 434;
  localparam int DIGIT = 64;
  localparam int ND    = ceil_div(WIDTH, DIGIT);

  localparam logic [447:0] P434_FULL = {
    64'h0002341F27177344,
    64'h6CFC5FD681C52056,
    64'h7BC65C783158AEA3,
    64'hFDC1767AE2FFFFFF,
    64'hFFFFFFFFFFFFFFFF,
    64'hFFFFFFFFFFFFFFFF,
    64'hFFFFFFFFFFFFFFFF
  };
  localparam logic [WIDTH-1:0] P434 = P434_FULL[WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/digit_addsub.sv
// One digit of add or subtract with carry/borrow chaining.
// Subtract reuses the adder as x + ~y + ~bin.
module digit_addsub #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          cin,
  input  logic          sub,
  output logic [DW-1:0] s,
  output logic          cout
);
  import sike_pkg::*;

  logic [DW-1:0] y_e;
  logic          c_e;
  logic [DW:0]   sum;

  always_comb begin
    y_e  = sub ? ~y : y;
    c_e  = sub ? ~cin : cin;
    sum  = {1'b0, x} + {1'b0, y_e} + {{DW{1'b0}}, c_e};
    s    = sum[DW-1:0];
    // a carry out of the inverted add means no borrow
    cout = sub ? ~sum[DW] : sum[DW];
  end

endmodule

// File: rtl/mod_sub_serial.sv
// Digit-serial (a - b) mod p: one subtract pass, then an
// add-back pass of p only when the subtract borrowed.
module mod_sub_serial #(
  parameter int WIDTH = sike_pkg::WIDTH,
  parameter int DIGIT = sike_pkg::DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  import sike_pkg::*;

  localparam int NDG = ceil_div(WIDTH, DIGIT);
  localparam int TW  = NDG * DIGIT;
  localparam int CW  = (NDG > 1) ? $clog2(NDG) : 1;
  localparam logic [CW-1:0] LAST  = CW'(NDG - 1);
  localparam logic [TW-1:0] P_EXT = TW'(P434);

  state_t state, state_nx;

  logic [TW-1:0]    a_sh;
  logic [TW-1:0]    b_sh;
  logic [TW-1:0]    diff;
  logic [CW-1:0]    cnt;
  logic             cb;
  logic             last;
  logic             is_fix;
  logic [DIGIT-1:0] x;
  logic [DIGIT-1:0] y;
  logic [DIGIT-1:0] s;
  logic [DIGIT-1:0] p_dig;
  logic             co;

  assign ready  = (state == IDLE);
  assign last   = (cnt == LAST);
  assign is_fix = (state == FIX);
  assign p_dig  = DIGIT'(P_EXT >> (int'(cnt) * DIGIT));
  // diff rotates through the low digit in both passes
  assign x      = is_fix ? diff[DIGIT-1:0] : a_sh[DIGIT-1:0];
  assign y      = is_fix ? p_dig : b_sh[DIGIT-1:0];

  digit_addsub #(
    .DW (DIGIT)
  ) u_dig (
    .x    (x),
    .y    (y),
    .cin  (cb),
    .sub  (~is_fix),
    .s    (s),
    .cout (co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = SUB;
      SUB:  if (last)  state_nx = co ? FIX : DONE;
      FIX:  if (last)  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff   <= '0;
      cnt    <= '0;
      cb     <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh <= TW'(a);
            b_sh <= TW'(b);
            cnt  <= '0;
            cb   <= 1'b0;
          end
        end
        SUB: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          diff <= TW'({s, diff} >> DIGIT);
          cnt  <= last ? '0 : cnt + 1'b1;
          cb   <= last ? 1'b0 : co;
        end
        FIX: begin
          diff <= TW'({s, diff} >> DIGIT);
          cnt  <= last ? '0 : cnt + 1'b1;
          cb   <= last ? 1'b0 : co;
        end
        DONE: begin
          done   <= 1'b1;
          result <= diff[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mod_sub_serial.md
MOD_SUB_SERIAL -- requirements
Module: mod_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 434; operand/modulus bit width.
REQ-002 SHALL have parameter DIGIT, default 64; bits processed per cycle; ND = ceil(WIDTH/DIGIT) = 7 at defaults.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, request pulse; sampled only when ready=1.
REQ-006 SHALL have port a, input, WIDTH, minuend, required a < p.
REQ-007 SHALL have port b, input, WIDTH, subtrahend, required b < p.
REQ-008 SHALL have port ready, output, 1, high in IDLE only.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, WIDTH, (a - b) mod p; held until the next accepted start.

Function
REQ-011 SHALL implement the FSM states IDLE, SUB, FIX, DONE.
REQ-012 IDLE: when start=1, SHALL latch a and b, clear borrow and the digit counter, and go to SUB; start=0 stays in IDLE.
REQ-013 SUB: each cycle SHALL compute digit k of a - b - borrow_in and store the borrow-out; after digit ND-1 it SHALL go to FIX if the final borrow=1, else to DONE.
REQ-014 FIX: each cycle SHALL add digit k of p plus carry to the stored difference; after digit ND-1 it SHALL go to DONE, and the final carry SHALL be discarded.
REQ-015 DONE: SHALL assert done for exactly one cycle, update result, and return to IDLE.
REQ-016 Latency from the start-accept edge to done high SHALL be ND+1 cycles (8) with no borrow, and 2*ND+1 cycles (15) with a borrow.
REQ-017 The top digit SHALL be zero-extended above WIDTH, and bits above WIDTH SHALL never reach result.
REQ-018 start while ready=0 SHALL be ignored with no effect on the current operation.
REQ-019 a and b changing after acceptance SHALL not affect the result.
REQ-020 The digit counter SHALL wrap to 0 on the SUB->FIX transition and SHALL never exceed ND-1.
REQ-021 Inputs with a >= p or b >= p are outside contract; the result is unspecified, but the FSM SHALL still return to IDLE within 2*ND+1 cycles.

Reset
REQ-022 When rst_n=0 at a clk edge: state=IDLE, ready=1, done=0, result=0, counter=0, borrow/carry=0.
REQ-023 Reset mid-operation (SUB or FIX) SHALL abort the operation, and no done pulse SHALL follow.
REQ-024 start coincident with rst_n=0 SHALL be ignored.

Structure
REQ-025 A shared package sike_pkg SHALL hold WIDTH, DIGIT, ND, the modulus constant P434, and the state encoding.
REQ-026 One sub-module digit_addsub SHALL provide a combinational DIGIT-bit add/subtract with carry/borrow in/out and a mode select; it SHALL be used in both SUB and FIX.
REQ-027 The datapath SHALL be DIGIT bits wide, with operands shifted or indexed by digit; no full-width adder.

Verification
REQ-028 Scenario 1: a=5, b=3, start -> done at cycle 8, result=2.
REQ-029 Scenario 2: a=3, b=5 -> done at cycle 15, result=p-2.
REQ-030 Scenario 3: a=b=0x1234...(any <p) -> result=0, no FIX (done at cycle 8).
REQ-031 Scenario 4: a=0, b=p-1 -> result=1, done at cycle 15; a=p-1, b=0 -> result=p-1, done at cycle 8.
REQ-032 Scenario 5: start pulses during SUB and FIX -> ignored; exactly one done pulse and the original result.
REQ-033 Scenario 6: rst_n=0 at cycle 10 of a borrow case -> next cycle ready=1, result=0, no done; a new start then completes normally.
